// File: rtl/lpc_post_code_snooper.sv
// Passive LPC observer: captures host I/O writes to PORT_ADDR as a POST code.
// Optional LPC_SYNC_CHECK_EN makes the commit wait for a ready SYNC from the peripheral.
module lpc_post_code_snooper #(
    parameter logic [15:0] PORT_ADDR    = 16'h0080,
    parameter int unsigned SYNC_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lad,
    input  logic       lframe_n,
    output logic [7:0] post_code,
    output logic       post_valid,
    output logic       post_seen
);

    localparam logic [3:0] START_CODE   = 4'b0000;
    localparam logic [3:0] CYC_IO_WRITE = 4'b0010;

    if (SYNC_TIMEOUT < 2) begin : g_bad_timeout
        $error("SYNC_TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CYCTYPE = 3'd1,
        ADDR    = 3'd2,
        DATA0   = 3'd3,
        DATA1   = 3'd4
`ifdef LPC_SYNC_CHECK_EN
        ,
        TAR     = 3'd5,
        SYNC    = 3'd6
`endif
    } state_t;

    state_t      state;
    logic [1:0]  nib_cnt;
    logic [15:0] addr;
    logic [3:0]  data_lo;

`ifdef LPC_SYNC_CHECK_EN
    localparam int unsigned CNT_W      = $clog2(SYNC_TIMEOUT);
    localparam logic [3:0]  SYNC_READY = 4'b0000;
    localparam logic [3:0]  SYNC_SHORT = 4'b0101;
    localparam logic [3:0]  SYNC_LONG  = 4'b0110;

    logic [3:0]       data_hi;
    logic [CNT_W-1:0] sync_cnt;
`endif

    // Decode FSM; an LFRAME# low cycle overrides whatever phase is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            nib_cnt    <= '0;
            addr       <= '0;
            data_lo    <= '0;
            post_code  <= '0;
            post_valid <= 1'b0;
            post_seen  <= 1'b0;
`ifdef LPC_SYNC_CHECK_EN
            data_hi    <= '0;
            sync_cnt   <= '0;
`endif
        end else begin
            post_valid <= 1'b0;
            if (!lframe_n) begin
                state   <= (lad == START_CODE) ? CYCTYPE : IDLE;
                nib_cnt <= '0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    CYCTYPE: state <= (lad == CYC_IO_WRITE) ? ADDR : IDLE;
                    ADDR: begin
                        addr    <= {addr[11:0], lad};
                        nib_cnt <= nib_cnt + 2'd1;
                        if (nib_cnt == 2'd3) state <= DATA0;
                    end
                    DATA0: begin
                        data_lo <= lad;
                        state   <= DATA1;
                    end
`ifdef LPC_SYNC_CHECK_EN
                    DATA1: begin
                        data_hi <= lad;
                        nib_cnt <= '0;
                        state   <= TAR;
                    end
                    TAR: begin
                        nib_cnt <= nib_cnt + 2'd1;
                        if (nib_cnt == 2'd1) begin
                            sync_cnt <= '0;
                            state    <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (lad == SYNC_READY) begin
                            if (addr == PORT_ADDR) begin
                                post_code  <= {data_hi, data_lo};
                                post_valid <= 1'b1;
                                post_seen  <= 1'b1;
                            end
                            state <= IDLE;
                        end else if (lad == SYNC_SHORT || lad == SYNC_LONG) begin
                            // Waiting peripheral: give up once the wait budget is spent
                            if (sync_cnt == CNT_W'(SYNC_TIMEOUT - 1)) state <= IDLE;
                            else sync_cnt <= sync_cnt + CNT_W'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
`else
                    DATA1: begin
                        if (addr == PORT_ADDR) begin
                            post_code  <= {lad, data_lo};
                            post_valid <= 1'b1;
                            post_seen  <= 1'b1;
                        end
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_post_code_snooper.sv
// Bench for lpc_post_code_snooper: directed scenarios plus random LPC traffic,
// checked every cycle against a window-matching model of the captured cycle.
module tb_lpc_post_code_snooper;

    localparam logic [15:0] PORT = 16'h0080;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lframe_n = 1'b1;
    logic [3:0] lad = 4'h0;
    logic [7:0] post_code;
    logic       post_valid;
    logic       post_seen;

    lpc_post_code_snooper #(.PORT_ADDR(PORT), .SYNC_TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .lad       (lad),
        .lframe_n  (lframe_n),
        .post_code (post_code),
        .post_valid(post_valid),
        .post_seen (post_seen)
    );

    always #15 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: samples since the most recent LFRAME# low cycle; a commit is a pattern over that window.
    logic [4:0] hist[$];
    bit         have_start = 0;
    bit         armed = 0;
    logic [7:0] exp_code = 8'h00;
    bit         exp_valid = 0;
    bit         exp_seen = 0;

    function automatic bit commit_now(output logic [7:0] d);
        int e;
        bit ok;
        d = 8'h00;
        e = hist.size() - 1;
`ifdef LPC_SYNC_CHECK_EN
        if (e < 10 || e - 10 > 63) return 0;
        if (hist[e][3:0] != 4'h0) return 0;
        for (int i = 10; i < e; i++)
            if (hist[i][3:0] != 4'h5 && hist[i][3:0] != 4'h6) return 0;
`else
        if (e != 7) return 0;
`endif
        ok = (hist[0][3:0] == 4'h0) && (hist[1][3:0] == 4'h2) &&
             ({hist[2][3:0], hist[3][3:0], hist[4][3:0], hist[5][3:0]} == PORT);
        d = {hist[7][3:0], hist[6][3:0]};
        return ok;
    endfunction

    always @(posedge clk) begin
        logic [7:0] d;
        if (reset) begin
            hist.delete();
            have_start = 0;
            exp_code   = 8'h00;
            exp_valid  = 0;
            exp_seen   = 0;
            armed      = 1;
        end else begin
            if (!lframe_n) begin
                hist.delete();
                hist.push_back({1'b0, lad});
                have_start = 1;
            end else if (have_start && hist.size() < 100) begin
                hist.push_back({1'b1, lad});
            end
            exp_valid = 0;
            if (have_start && commit_now(d)) begin
                exp_valid = 1;
                exp_code  = d;
                exp_seen  = 1;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("post_valid", 32'(post_valid), 32'(exp_valid));
            check("post_code", 32'(post_code), 32'(exp_code));
            check("post_seen", 32'(post_seen), 32'(exp_seen));
            if (post_valid === 1'b1) strobes++;
        end
    end

    task automatic cyc(input logic r, input logic lf, input logic [3:0] d);
        @(negedge clk);
        reset    = r;
        lframe_n = lf;
        lad      = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 4'($urandom));
    endtask

    // One LPC cycle; abort_at replaces that step with an LFRAME# low cycle and stops.
    task automatic xfer(input logic [3:0] ct, input logic [15:0] a, input logic [7:0] d,
                        input int waits, input logic [3:0] wcode, input logic [3:0] send,
                        input int abort_at);
        logic [4:0] seq[$];
        seq.push_back({1'b0, 4'h0});
        seq.push_back({1'b1, ct});
        seq.push_back({1'b1, a[15:12]});
        seq.push_back({1'b1, a[11:8]});
        seq.push_back({1'b1, a[7:4]});
        seq.push_back({1'b1, a[3:0]});
        seq.push_back({1'b1, d[3:0]});
        seq.push_back({1'b1, d[7:4]});
`ifdef LPC_SYNC_CHECK_EN
        seq.push_back({1'b1, 4'($urandom)});
        seq.push_back({1'b1, 4'($urandom)});
        for (int i = 0; i < waits; i++) seq.push_back({1'b1, wcode});
        seq.push_back({1'b1, send});
`endif
        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_at) begin
                cyc(1'b0, 1'b0, 4'($urandom));
                return;
            end
            cyc(1'b0, seq[i][4], seq[i][3:0]);
        end
    endtask

    initial begin
        int s0;
        cyc(1'b1, 1'b1, 4'h0);
        cyc(1'b1, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        check("rst_code", 32'(post_code), 32'h00);
        check("rst_valid", 32'(post_valid), 32'h0);
        check("rst_seen", 32'(post_seen), 32'h0);

        // Matching write 0x5A: strobe in the cycle right after the last phase
        xfer(4'h2, 16'h0080, 8'h5A, 0, 4'h5, 4'h0, -1);
        cyc(1'b0, 1'b1, 4'hF);
        check("t1_valid", 32'(post_valid), 32'h1);
        check("t1_model_valid", 32'(exp_valid), 32'h1);
        check("t1_code", 32'(post_code), 32'h5A);
        check("t1_seen", 32'(post_seen), 32'h1);
        cyc(1'b0, 1'b1, 4'hF);
        check("t1_valid_drop", 32'(post_valid), 32'h0);

        // Wrong address, then an I/O read of the port
        s0 = strobes;
        xfer(4'h2, 16'h0081, 8'h33, 0, 4'h5, 4'h0, -1);
        xfer(4'h0, 16'h0080, 8'h77, 0, 4'h5, 4'h0, -1);
        idle(3);
        check("t2_code", 32'(post_code), 32'h5A);
        check("t2_model_code", 32'(exp_code), 32'h5A);
        check("t2_strobes", 32'(strobes - s0), 32'd0);

        // START during the second address nibble, then back-to-back START into a full write
        s0 = strobes;
        cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h2);
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b0, 4'h0);
        xfer(4'h2, 16'h0080, 8'hC3, 0, 4'h5, 4'h0, -1);
        idle(2);
        check("t3_code", 32'(post_code), 32'hC3);
        check("t3_strobes", 32'(strobes - s0), 32'd1);

        // Reset at the DATA0 cycle of a matching write
        cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h2);
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h8);
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b1, 1'b1, 4'hA);
        cyc(1'b0, 1'b1, 4'h5);
        check("t4_rst_code", 32'(post_code), 32'h00);
        check("t4_rst_valid", 32'(post_valid), 32'h0);
        check("t4_rst_seen", 32'(post_seen), 32'h0);
        xfer(4'h2, 16'h0080, 8'h01, 0, 4'h5, 4'h0, -1);
        idle(2);
        check("t4_code", 32'(post_code), 32'h01);
        check("t4_seen", 32'(post_seen), 32'h1);

        // Back-to-back matching writes
        s0 = strobes;
        xfer(4'h2, 16'h0080, 8'h11, 0, 4'h5, 4'h0, -1);
        xfer(4'h2, 16'h0080, 8'h22, 0, 4'h5, 4'h0, -1);
        idle(3);
        check("t5_strobes", 32'(strobes - s0), 32'd2);
        check("t5_code", 32'(post_code), 32'h22);

`ifdef LPC_SYNC_CHECK_EN
        s0 = strobes;
        xfer(4'h2, 16'h0080, 8'h44, 3, 4'h5, 4'h0, -1);
        idle(2);
        check("f_wait_code", 32'(post_code), 32'h44);
        check("f_wait_strobes", 32'(strobes - s0), 32'd1);
        s0 = strobes;
        xfer(4'h2, 16'h0080, 8'h55, 1, 4'h6, 4'hA, -1);
        idle(2);
        check("f_err_code", 32'(post_code), 32'h44);
        check("f_err_strobes", 32'(strobes - s0), 32'd0);
        s0 = strobes;
        xfer(4'h2, 16'h0080, 8'h66, 64, 4'h6, 4'h0, -1);
        idle(2);
        check("f_tmo_code", 32'(post_code), 32'h44);
        check("f_tmo_strobes", 32'(strobes - s0), 32'd0);
        s0 = strobes;
        xfer(4'h2, 16'h0080, 8'h67, 63, 4'h6, 4'h0, -1);
        idle(2);
        check("f_edge_code", 32'(post_code), 32'h67);
        check("f_edge_strobes", 32'(strobes - s0), 32'd1);
`endif

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            logic [15:0] a;
            logic [3:0]  ct;
            logic [3:0]  snd;
            int          ab;
            int          w;
            if ($urandom_range(0, 99) < 3) cyc(1'b1, 1'b1, 4'($urandom));
            a   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : PORT;
            ct  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h2;
            ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 11)) : -1;
            w   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(60, 66)) : int'($urandom_range(0, 4));
            snd = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            xfer(ct, a, 8'($urandom), w, ($urandom_range(0, 1) == 0) ? 4'h5 : 4'h6, snd, ab);
            idle(int'($urandom_range(0, 2)));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
